// File: rtl/btn_debouncer_if.sv
// Button conditioner bundle: raw pins and clear mask in, clean levels, strobes and flags out.
`timescale 1ns/1ps
interface btn_debouncer_if #(
    parameter int unsigned NBTNS = 5
);
    logic [NBTNS-1:0] i_btn;
    logic [NBTNS-1:0] i_clear;
    logic [NBTNS-1:0] o_btn;
    logic [NBTNS-1:0] o_press;
    logic [NBTNS-1:0] o_release;
    logic [NBTNS-1:0] o_pending;
    logic             o_int;

    modport master (
        output i_btn, i_clear,
        input  o_btn, o_press, o_release, o_pending, o_int
    );

    modport slave (
        input  i_btn, i_clear,
        output o_btn, o_press, o_release, o_pending, o_int
    );
endinterface

// File: rtl/btn_debouncer.sv
// Front-panel input conditioner: 2-flop synchronizer plus per-button stability counter,
// producing debounced levels, press/release strobes and sticky pending flags.
`timescale 1ns/1ps
module btn_debouncer #(
    parameter int unsigned NBTNS   = 5,
    parameter int unsigned DBCOUNT = 100000,
    parameter int unsigned DBW     = 17,
    parameter bit          INVERT  = 1'b0
) (
    input logic            i_clk,
    input logic            i_reset_n,
    btn_debouncer_if.slave bus
);

    // Synchronizer resets to the idle pin level so the normalized level starts at 0.
    localparam logic [NBTNS-1:0] SyncInit = {NBTNS{INVERT}};
    localparam logic [DBW-1:0]   CntMax   = DBW'(DBCOUNT - 1);

    logic [NBTNS-1:0] sync1_q, sync2_q, lvl;
    logic [NBTNS-1:0] btn_q, btn_d;
    logic [NBTNS-1:0] press_q, press_d;
    logic [NBTNS-1:0] release_q, release_d;
    logic [NBTNS-1:0] pending_q, pending_d;
    logic [DBW-1:0]   cnt_q [NBTNS];
    logic [DBW-1:0]   cnt_d [NBTNS];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1_q <= SyncInit;
            sync2_q <= SyncInit;
        end else begin
            sync1_q <= bus.i_btn;
            sync2_q <= sync1_q;
        end
    end

    assign lvl = sync2_q ^ SyncInit;

    always_comb begin
        btn_d     = btn_q;
        press_d   = '0;
        release_d = '0;
        for (int k = 0; k < NBTNS; k++) begin
            cnt_d[k] = '0;
            // Any sample matching the current level restarts the stability window.
            if (lvl[k] != btn_q[k]) begin
                if (cnt_q[k] == CntMax) begin
                    btn_d[k]     = lvl[k];
                    press_d[k]   = lvl[k];
                    release_d[k] = ~lvl[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end
        end
        // A press registered this edge wins over a simultaneous clear.
        pending_d = (pending_q & ~bus.i_clear) | press_d;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            btn_q     <= '0;
            press_q   <= '0;
            release_q <= '0;
            pending_q <= '0;
            for (int k = 0; k < NBTNS; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            btn_q     <= btn_d;
            press_q   <= press_d;
            release_q <= release_d;
            pending_q <= pending_d;
            for (int k = 0; k < NBTNS; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign bus.o_btn     = btn_q;
    assign bus.o_press   = press_q;
    assign bus.o_release = release_q;
    assign bus.o_pending = pending_q;
    assign bus.o_int     = |pending_q;

endmodule

// File: tb/tb_btn_debouncer.sv
// Directed bench for btn_debouncer: timed expectations queued at stimulus, checked at sample points.
`timescale 1ns/1ps
module tb_btn_debouncer;

    typedef struct {
        int          cyc;
        bit          ph;
        bit          dut;
        string       tag;
        logic [20:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a_n;
    logic rst_b_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;
    int   c;
    exp_t sb[$];

    bit          mon_ph;
    logic [20:0] mon_obs;

    btn_debouncer_if #(.NBTNS(5)) a_if ();
    btn_debouncer_if #(.NBTNS(5)) b_if ();

    btn_debouncer #(
        .NBTNS(5), .DBCOUNT(4), .DBW(2), .INVERT(1'b0)
    ) u_dut_a (
        .i_clk     (clk),
        .i_reset_n (rst_a_n),
        .bus       (a_if.slave)
    );

    btn_debouncer #(
        .NBTNS(5), .DBCOUNT(4), .DBW(2), .INVERT(1'b1)
    ) u_dut_b (
        .i_clk     (clk),
        .i_reset_n (rst_b_n),
        .bus       (b_if.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_out(input bit dut, input int ec, input bit ph, input string tag,
                              input logic [4:0] bt, input logic [4:0] pr, input logic [4:0] rl,
                              input logic [4:0] pd, input logic it);
        exp_t e;
        e.cyc = ec;
        e.ph  = ph;
        e.dut = dut;
        e.tag = tag;
        e.exp = {bt, pr, rl, pd, it};
        sb.push_back(e);
    endtask

    // Samples 1ns after each clock edge; phase 0 = after rising edge, 1 = after falling edge.
    always begin
        @(clk);
        #1;
        mon_ph = !clk;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc && sb[i].ph == mon_ph) begin
                if (sb[i].dut)
                    mon_obs = {b_if.o_btn, b_if.o_press, b_if.o_release, b_if.o_pending, b_if.o_int};
                else
                    mon_obs = {a_if.o_btn, a_if.o_press, a_if.o_release, a_if.o_pending, a_if.o_int};
                checks++;
                assert (mon_obs === sb[i].exp) else begin
                    errors++;
                    $error("FAIL %s observed btn/press/rel/pend/int=%h expected=%h",
                           sb[i].tag, mon_obs, sb[i].exp);
                end
                sb.delete(i);
            end
        end
        if (done) begin
            checks++;
            assert (sb.size() == 0) else begin
                errors++;
                $error("FAIL sb_drained observed=%0d pending entries expected=0", sb.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        a_if.i_btn = 5'h1F;
        a_if.i_clear = 5'h00;
        b_if.i_btn = 5'h1F;
        b_if.i_clear = 5'h00;
        repeat (2) @(negedge clk);

        // Reset holds everything at zero even with all pins pressed.
        c = cyc;
        expect_out(0, c + 1, 0, "a_reset", 5'h00, 5'h00, 5'h00, 5'h00, 1'b0);
        expect_out(1, c + 1, 0, "b_reset", 5'h00, 5'h00, 5'h00, 5'h00, 1'b0);
        repeat (2) @(negedge clk);

        c = cyc;
        rst_a_n = 1'b1;
        expect_out(0, c + 5, 0, "a_pre_accept", 5'h00, 5'h00, 5'h00, 5'h00, 1'b0);
        expect_out(0, c + 6, 0, "a_press_all",  5'h1F, 5'h1F, 5'h00, 5'h1F, 1'b1);
        expect_out(0, c + 7, 0, "a_press_once", 5'h1F, 5'h00, 5'h00, 5'h1F, 1'b1);
        repeat (8) @(negedge clk);

        c = cyc;
        a_if.i_btn = 5'h00;
        expect_out(0, c + 5, 0, "a_rel_pre",  5'h1F, 5'h00, 5'h00, 5'h1F, 1'b1);
        expect_out(0, c + 6, 0, "a_release",  5'h00, 5'h00, 5'h1F, 5'h1F, 1'b1);
        expect_out(0, c + 7, 0, "a_rel_once", 5'h00, 5'h00, 5'h00, 5'h1F, 1'b1);
        repeat (8) @(negedge clk);

        c = cyc;
        a_if.i_clear = 5'h1F;
        expect_out(0, c + 1, 0, "a_clear_all", 5'h00, 5'h00, 5'h00, 5'h00, 1'b0);
        @(negedge clk);
        a_if.i_clear = 5'h00;
        repeat (2) @(negedge clk);

        // Three-cycle glitch on bit 1 must be rejected.
        c = cyc;
        a_if.i_btn = 5'h02;
        expect_out(0, c + 5, 0, "a_glitch_5", 5'h00, 5'h00, 5'h00, 5'h00, 1'b0);
        expect_out(0, c + 6, 0, "a_glitch_6", 5'h00, 5'h00, 5'h00, 5'h00, 1'b0);
        expect_out(0, c + 7, 0, "a_glitch_7", 5'h00, 5'h00, 5'h00, 5'h00, 1'b0);
        repeat (3) @(negedge clk);
        a_if.i_btn = 5'h00;
        repeat (6) @(negedge clk);

        // Bits 1 and 2 pressed; clear[2] coincides with the press edge.
        c = cyc;
        a_if.i_btn = 5'h06;
        expect_out(0, c + 5, 0, "a_p12_pre",   5'h00, 5'h00, 5'h00, 5'h00, 1'b0);
        expect_out(0, c + 6, 0, "a_p12_clr",   5'h06, 5'h06, 5'h00, 5'h06, 1'b1);
        expect_out(0, c + 7, 0, "a_p12_hold",  5'h06, 5'h00, 5'h00, 5'h06, 1'b1);
        expect_out(0, c + 9, 0, "a_clear_all2", 5'h06, 5'h00, 5'h00, 5'h00, 1'b0);
        repeat (5) @(negedge clk);
        a_if.i_clear = 5'h04;
        @(negedge clk);
        a_if.i_clear = 5'h00;
        repeat (2) @(negedge clk);
        a_if.i_clear = 5'h1F;
        @(negedge clk);
        a_if.i_clear = 5'h00;
        repeat (2) @(negedge clk);

        // Bit 0 then bit 3 two cycles later: strobes 2 cycles apart.
        c = cyc;
        a_if.i_btn = 5'h07;
        expect_out(0, c + 6, 0, "a_p0",      5'h07, 5'h01, 5'h00, 5'h01, 1'b1);
        expect_out(0, c + 7, 0, "a_p0_hold", 5'h07, 5'h00, 5'h00, 5'h01, 1'b1);
        expect_out(0, c + 8, 0, "a_p3",      5'h0F, 5'h08, 5'h00, 5'h09, 1'b1);
        expect_out(0, c + 9, 0, "a_p3_hold", 5'h0F, 5'h00, 5'h00, 5'h09, 1'b1);
        repeat (2) @(negedge clk);
        a_if.i_btn = 5'h0F;
        repeat (9) @(negedge clk);

        // Active-low instance: pin 0 low is a press.
        c = cyc;
        rst_b_n = 1'b1;
        b_if.i_btn = 5'h1E;
        expect_out(1, c + 5, 0, "b_pre",     5'h00, 5'h00, 5'h00, 5'h00, 1'b0);
        expect_out(1, c + 6, 0, "b_p0",      5'h01, 5'h01, 5'h00, 5'h01, 1'b1);
        expect_out(1, c + 7, 0, "b_p0_hold", 5'h01, 5'h00, 5'h00, 5'h01, 1'b1);
        repeat (8) @(negedge clk);

        // Pin 4 low; reset lands with its counter at 2.
        c = cyc;
        b_if.i_btn = 5'h0E;
        repeat (4) @(negedge clk);
        rst_b_n = 1'b0;
        expect_out(1, c + 4, 1, "b_async_rst", 5'h00, 5'h00, 5'h00, 5'h00, 1'b0);
        expect_out(1, c + 5, 0, "b_in_rst",    5'h00, 5'h00, 5'h00, 5'h00, 1'b0);
        repeat (2) @(negedge clk);

        c = cyc;
        rst_b_n = 1'b1;
        expect_out(1, c + 5, 0, "b_post_pre",  5'h00, 5'h00, 5'h00, 5'h00, 1'b0);
        expect_out(1, c + 6, 0, "b_post_p",    5'h11, 5'h11, 5'h00, 5'h11, 1'b1);
        expect_out(1, c + 7, 0, "b_post_hold", 5'h11, 5'h00, 5'h00, 5'h11, 1'b1);
        repeat (9) @(negedge clk);

        done = 1'b1;
        repeat (4) @(negedge clk);
    end

endmodule
